// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the SPI configuration frame engine: FSM states,
// header field positions and the default write-enable mask.
package spi_cfg_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int RW_BIT  = 7;
   localparam int IDX_MSB = 6;
   localparam int IDX_LSB = 4;
   localparam int AI_BIT  = 3;

   localparam logic [7:0] WR_MASK_DEF = 8'b0000_0011;

endpackage

// File: rtl/spi_shift_8.sv
// 8-bit shift register with parallel load; dir = 0 shifts toward the MSB
// (serial in at bit 0), dir = 1 shifts toward the LSB (serial in at bit 7).
module spi_shift_8 (
   input  logic       spi_clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] din,
   input  logic       shift,
   input  logic       dir,
   input  logic       sin,
   output logic [7:0] q
);

   always_ff @(posedge spi_clk or negedge rst_n) begin
      if (!rst_n)     q <= '0;
      else if (load)  q <= din;
      else if (shift) q <= dir ? {sin, q[7:1]} : {q[6:0], sin};
   end

endmodule

// File: rtl/spi_cfg_ctrl.sv
// SPI-slave frame engine: header + data byte(s) in on sdi, register-file
// write strobe out, read data serialised on sdo. Burst mode: SPI_CFG_BURST_EN.
module spi_cfg_ctrl
   import spi_cfg_pkg::*;
#(
   parameter int         DATA_W  = 8,
   parameter int         IDX_W   = 3,
   parameter logic [7:0] WR_MASK = WR_MASK_DEF
) (
   input  logic              spi_clk,
   input  logic              rst_n,
   input  logic              spi_cs_n,
   input  logic              sdi,
   input  logic [DATA_W-1:0] read_data,
   output logic              sdo,
   output logic              sdo_oe,
   output logic [DATA_W-1:0] spi_if_dout,
   output logic [IDX_W-1:0]  spi_if_index,
   output logic              spi_if_wr_en,
   output logic              wr_err,
   output logic              busy
);

   state_t     state;
   logic [2:0] cnt;
   logic       rw;
   logic       nxt_byte;
   logic       burst;
   logic [7:0] rx_q, tx_q;
   logic [7:0] byte_w;
   logic       tx_load, tx_shift;
   logic       unused_bits;

`ifdef SPI_CFG_BURST_EN
   logic ai;
   assign burst = ai;
`else
   assign burst = 1'b0;
`endif

   // byte as it stands including the bit being sampled on this edge
   assign byte_w      = {rx_q[6:0], sdi};
   assign busy        = (state != IDLE);
   assign unused_bits = ^{rx_q[7], tx_q[6:0]};

   always_comb begin
      tx_load  = 1'b0;
      tx_shift = 1'b0;
      if (!spi_cs_n) begin
         tx_load  = (state == HDR && cnt == 3'd7 && !byte_w[RW_BIT]) ||
                    (state == DATA && !rw && cnt == 3'd7 && burst);
         tx_shift = (state == DATA && !rw && cnt != 3'd7);
      end
   end

   spi_shift_8 u_rx (
      .spi_clk (spi_clk),
      .rst_n   (rst_n),
      .load    (1'b0),
      .din     (8'h00),
      .shift   (!spi_cs_n),
      .dir     (1'b0),
      .sin     (sdi),
      .q       (rx_q)
   );

   spi_shift_8 u_tx (
      .spi_clk (spi_clk),
      .rst_n   (rst_n),
      .load    (tx_load),
      .din     ({read_data[6:0], 1'b0}),
      .shift   (tx_shift),
      .dir     (1'b0),
      .sin     (1'b0),
      .q       (tx_q)
   );

   always_ff @(posedge spi_clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         rw           <= 1'b0;
         nxt_byte     <= 1'b0;
         sdo          <= 1'b0;
         sdo_oe       <= 1'b0;
         spi_if_dout  <= '0;
         spi_if_index <= '0;
         spi_if_wr_en <= 1'b0;
         wr_err       <= 1'b0;
`ifdef SPI_CFG_BURST_EN
         ai           <= 1'b0;
`endif
      end else begin
         // strobe is one cycle wide, even across an abort edge
         spi_if_wr_en <= 1'b0;
         if (spi_cs_n) begin
            state    <= IDLE;
            cnt      <= '0;
            sdo_oe   <= 1'b0;
            nxt_byte <= 1'b0;
         end else begin
            cnt <= cnt + 3'd1;
            case (state)
               IDLE: state <= HDR;
               HDR: begin
                  if (cnt == 3'd3)
                     spi_if_index <= byte_w[IDX_MSB-IDX_LSB:0];
                  if (cnt == 3'd7) begin
                     rw       <= byte_w[RW_BIT];
`ifdef SPI_CFG_BURST_EN
                     ai       <= byte_w[AI_BIT];
`endif
                     nxt_byte <= 1'b0;
                     state    <= DATA;
                     if (!byte_w[RW_BIT]) begin
                        sdo    <= read_data[7];
                        sdo_oe <= 1'b1;
                     end
                  end
               end
               DATA: begin
                  if (rw) begin
                     if (cnt == 3'd0 && nxt_byte)
                        spi_if_index <= spi_if_index + 1'b1;
                     if (cnt == 3'd7) begin
                        spi_if_dout <= byte_w;
                        if (WR_MASK[spi_if_index]) spi_if_wr_en <= 1'b1;
                        else                       wr_err       <= 1'b1;
                     end
                  end else begin
                     // index moves on once this byte's read data is in tx
                     if (cnt == 3'd0 && burst)
                        spi_if_index <= spi_if_index + 1'b1;
                     if (cnt != 3'd7) sdo <= tx_q[7];
                     else if (burst)  sdo <= read_data[7];
                  end
                  if (cnt == 3'd7) begin
                     if (burst) nxt_byte <= 1'b1;
                     else begin
                        state  <= DONE;
                        sdo_oe <= 1'b0;
                     end
                  end
               end
               DONE: state <= DONE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
